// File: rtl/l1_cache_ctrl_if.sv
// ---------------------------------------------------------------------------
// l1_cache_ctrl_if
// Core-side request/hold bus between the multicycle core and the L1 cache.
//   cpu_ce_n  : request strobe, active-low (core -> cache)
//   cpu_we_n  : 0 = write, 1 = read       (core -> cache)
//   cpu_bw    : 1 = word write, 0 = byte write of cpu_wdata[7:0] (core -> cache)
//   cpu_addr  : byte address               (core -> cache)
//   cpu_wdata : write data                 (core -> cache)
//   cpu_rdata : read data                  (cache -> core)
//   hold      : stall the core             (cache -> core)
// master = core side, slave = cache side.
// ---------------------------------------------------------------------------
interface l1_cache_ctrl_if;
  logic        cpu_ce_n;
  logic        cpu_we_n;
  logic        cpu_bw;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        hold;

  modport master (
    output cpu_ce_n, cpu_we_n, cpu_bw, cpu_addr, cpu_wdata,
    input  cpu_rdata, hold
  );

  modport slave (
    input  cpu_ce_n, cpu_we_n, cpu_bw, cpu_addr, cpu_wdata,
    output cpu_rdata, hold
  );
endinterface

// File: rtl/l1_cache_ctrl.sv
// ---------------------------------------------------------------------------
// l1_cache_ctrl
// Direct-mapped, write-through, write-allocate L1 cache between the core
// request/hold bus and a single-word memory with a one-cycle ack pulse.
// A miss refills the whole line with LINE_WORDS sequential reads; every
// write (hit or after refill) is written through as a full word.
//
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   cpu              : core bus (l1_cache_ctrl_if.slave)
//   mem_ce_n         : memory request strobe, one cycle per access
//   mem_we_n         : memory write enable (active-low)
//   mem_oe_n         : memory output enable (active-low)
//   mem_bw           : tied to 1 (full-word accesses only)
//   mem_addr         : memory byte address of the word being accessed
//   mem_data         : shared tristate data bus, driven only in WB_REQ
//   mem_ack          : one-cycle completion pulse from memory
//   stat_hits/misses : saturating counters, present only when the macro
//                      L1_CACHE_STATS_EN is defined
// ---------------------------------------------------------------------------
module l1_cache_ctrl #(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  l1_cache_ctrl_if.slave     cpu,
  output logic               mem_ce_n,
  output logic               mem_we_n,
  output logic               mem_oe_n,
  output logic               mem_bw,
  output logic [31:0]        mem_addr,
  inout  wire  [31:0]        mem_data,
  input  logic               mem_ack
`ifdef L1_CACHE_STATS_EN
  ,
  output logic [31:0]        stat_hits,
  output logic [31:0]        stat_misses
`endif
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int ADDR_W = OFF_W + IDX_W;
  localparam int TAG_W  = 30 - ADDR_W;
  localparam int K_W    = OFF_W + 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_GAP, S_WB_REQ, S_WB_WAIT, S_DONE
  } state_t;

  state_t                state;
  logic [NUM_LINES-1:0]  valid;
  logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
  logic [31:0]           data_mem [NUM_LINES*LINE_WORDS];

  logic [K_W-1:0]        k;
  logic [K_W-1:0]        k_nxt;
  logic [31:0]           base_addr;
  logic [31:0]           wb_data;
  logic                  mem_drv;

  logic [ADDR_W-1:0]     cpu_ent;
  logic [IDX_W-1:0]      cpu_idx;
  logic [TAG_W-1:0]      cpu_tag;
  logic [31:0]           cpu_base;
  logic [IDX_W-1:0]      base_idx;
  logic [TAG_W-1:0]      base_tag;
  logic [ADDR_W-1:0]     fill_ent;

  logic                  req;
  logic                  hit;
  logic [31:0]           hit_word;
  logic [31:0]           merged;
  logic                  start_miss;
  logic                  start_wb;
  logic                  hold_c;

  function automatic logic [31:0] merge_byte(input logic [31:0] w,
                                             input logic [7:0]  b,
                                             input logic [1:0]  lane);
    logic [31:0] r;
    r = w;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

`ifdef L1_CACHE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Set when a refill returns to IDLE, so the held request's second
  // evaluation (now a hit) is not counted as a fresh hit.
  logic reeval;
`endif

  // Address split: {tag, index, word offset, byte offset}. The low ADDR_W
  // bits of the word address directly form the data-array entry.
  assign cpu_ent  = cpu.cpu_addr[ADDR_W+1:2];
  assign cpu_idx  = cpu.cpu_addr[ADDR_W+1:OFF_W+2];
  assign cpu_tag  = cpu.cpu_addr[31:ADDR_W+2];
  assign cpu_base = {cpu.cpu_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
  assign base_idx = base_addr[ADDR_W+1:OFF_W+2];
  assign base_tag = base_addr[31:ADDR_W+2];
  assign fill_ent = base_addr[ADDR_W+1:2] + ADDR_W'(k);
  assign k_nxt    = k + 1'b1;

  assign req        = !cpu.cpu_ce_n;
  assign hit        = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign hit_word   = data_mem[cpu_ent];
  assign merged     = cpu.cpu_bw ? cpu.cpu_wdata
                                 : merge_byte(hit_word, cpu.cpu_wdata[7:0], cpu.cpu_addr[1:0]);
  assign start_miss = (state == S_IDLE) && req && !hit;
  assign start_wb   = (state == S_IDLE) && req && !cpu.cpu_we_n && hit;

  // hold and read data must respond in the same cycle as the request, so
  // they are decoded combinationally from the state and the hit result.
  always_comb begin
    hold_c = 1'b1;
    case (state)
      S_IDLE:  hold_c = req && !(cpu.cpu_we_n && hit);
      S_DONE:  hold_c = 1'b0;
      default: hold_c = 1'b1;
    endcase
  end

  assign cpu.hold      = hold_c;
  assign cpu.cpu_rdata = ((state == S_IDLE) && req && cpu.cpu_we_n && hit) ? hit_word : 32'd0;

  assign mem_bw   = 1'b1;
  assign mem_data = mem_drv ? wb_data : {32{1'bz}};

  // Control FSM with registered memory-side outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      valid    <= '0;
      k        <= '0;
      mem_ce_n <= 1'b1;
      mem_we_n <= 1'b1;
      mem_oe_n <= 1'b1;
      mem_addr <= 32'd0;
      mem_drv  <= 1'b0;
`ifdef L1_CACHE_STATS_EN
      stat_hits   <= 32'd0;
      stat_misses <= 32'd0;
      reeval      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
`ifdef L1_CACHE_STATS_EN
          reeval <= 1'b0;
          if (req && hit && !reeval) stat_hits <= sat_inc(stat_hits);
          if (start_miss)            stat_misses <= sat_inc(stat_misses);
`endif
          if (start_miss) begin
            state    <= S_REQ;
            k        <= '0;
            mem_ce_n <= 1'b0;
            mem_we_n <= 1'b1;
            mem_oe_n <= 1'b0;
            mem_addr <= cpu_base;
          end else if (start_wb) begin
            state    <= S_WB_REQ;
            mem_ce_n <= 1'b0;
            mem_we_n <= 1'b0;
            mem_oe_n <= 1'b1;
            mem_drv  <= 1'b1;
            mem_addr <= {cpu.cpu_addr[31:2], 2'b00};
          end
        end
        S_REQ: begin
          state    <= S_WAIT;
          mem_ce_n <= 1'b1;
        end
        S_WAIT: begin
          if (mem_ack) begin
            state    <= S_GAP;
            mem_oe_n <= 1'b1;
          end
        end
        // GAP keeps ce_n high for a cycle so the memory's lingering data
        // drive never overlaps the next request.
        S_GAP: begin
          if (k != K_LAST) begin
            state    <= S_REQ;
            k        <= k_nxt;
            mem_ce_n <= 1'b0;
            mem_oe_n <= 1'b0;
            mem_addr <= base_addr + (32'(k_nxt) << 2);
          end else begin
            state           <= S_IDLE;
            valid[base_idx] <= 1'b1;
`ifdef L1_CACHE_STATS_EN
            reeval          <= 1'b1;
`endif
          end
        end
        S_WB_REQ: begin
          state    <= S_WB_WAIT;
          mem_ce_n <= 1'b1;
          mem_we_n <= 1'b1;
          mem_drv  <= 1'b0;
        end
        S_WB_WAIT: begin
          if (mem_ack) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath: tag/data arrays and latched addresses/data, not reset.
  always_ff @(posedge clk) begin
    if (start_miss) base_addr <= cpu_base;
    if (start_wb) begin
      wb_data           <= merged;
      data_mem[cpu_ent] <= merged;
    end
    if ((state == S_WAIT) && mem_ack) data_mem[fill_ent] <= mem_data;
    if ((state == S_GAP) && (k == K_LAST)) tag_mem[base_idx] <= base_tag;
  end

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_l1_cache_ctrl
// Self-checking bench for l1_cache_ctrl (NUM_LINES=16, LINE_WORDS=4) with a
// latency-16 memory model that acks one cycle and lingers its data drive
// for one extra cycle. Expected read data is pushed to a scoreboard queue
// when a read is issued and popped when the cache releases hold.
// Optional counters are checked when L1_CACHE_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_l1_cache_ctrl;
  localparam int LATENCY = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  l1_cache_ctrl_if cif();

  logic        mem_ce_n, mem_we_n, mem_oe_n, mem_bw;
  logic [31:0] mem_addr;
  wire  [31:0] mem_data;
  logic        mem_ack = 1'b0;
`ifdef L1_CACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  l1_cache_ctrl #(.NUM_LINES(16), .LINE_WORDS(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cpu(cif),
    .mem_ce_n(mem_ce_n),
    .mem_we_n(mem_we_n),
    .mem_oe_n(mem_oe_n),
    .mem_bw(mem_bw),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mem_ack(mem_ack)
`ifdef L1_CACHE_STATS_EN
    ,
    .stat_hits(stat_hits),
    .stat_misses(stat_misses)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // ---------------- memory model ----------------
  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0101);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'h3FF);
  endfunction

  logic [31:0] wmem [int];
  logic [31:0] rd_addrs [$];
  logic [31:0] last_wr_addr = 32'd0;
  logic [31:0] last_wr_data = 32'd0;
  int          ce_cnt = 0;
  int          cnt = 0;
  logic        rd_pend = 1'b0;
  logic [31:0] pend_addr = 32'd0;
  logic        drv_ack = 1'b0;
  logic        drv_lng = 1'b0;
  logic [31:0] rdv = 32'd0;

  function automatic logic [31:0] mem_rd(input int i);
    return wmem.exists(i) ? wmem[i] : pat(i);
  endfunction

  assign mem_data = (drv_ack | drv_lng) ? rdv : {32{1'bz}};

  always @(posedge clk) begin
    mem_ack <= 1'b0;
    drv_ack <= 1'b0;
    drv_lng <= drv_ack;
    if (cnt > 1) cnt <= cnt - 1;
    else if (cnt == 1) begin
      cnt     <= 0;
      mem_ack <= 1'b1;
      if (rd_pend) begin
        drv_ack <= 1'b1;
        rdv     <= mem_rd(widx(pend_addr));
      end
    end
    if (mem_ce_n == 1'b0) begin
      cnt       <= LATENCY;
      rd_pend   <= mem_we_n;
      pend_addr <= mem_addr;
      ce_cnt    <= ce_cnt + 1;
      if (mem_we_n == 1'b0) begin
        wmem[widx(mem_addr)] = mem_data;
        last_wr_addr <= mem_addr;
        last_wr_data <= mem_data;
      end else begin
        rd_addrs.push_back(mem_addr);
      end
    end
  end

  // ---------------- golden model and scoreboard ----------------
  logic [31:0] gold [int];
  logic [31:0] sb [$];

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return gold.exists(widx(a)) ? gold[widx(a)] : pat(widx(a));
  endfunction

  task automatic access(input string tag, input logic we_n, input logic bw,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int hc, output logic [31:0] rdata);
    @(negedge clk);
    cif.cpu_ce_n  = 1'b0;
    cif.cpu_we_n  = we_n;
    cif.cpu_bw    = bw;
    cif.cpu_addr  = addr;
    cif.cpu_wdata = wdata;
    hc = 0;
    while (1'b1) begin
      #1;
      if (!cif.hold) break;
      hc++;
      if (hc > 500) begin
        chk({tag, "_timeout"}, 32'(cif.hold), 32'd0);
        break;
      end
      @(negedge clk);
    end
    rdata = cif.cpu_rdata;
    @(posedge clk);
    #1;
    cif.cpu_ce_n = 1'b1;
    cif.cpu_we_n = 1'b1;
    cif.cpu_bw   = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input int exp_hold, input int exp_ce);
    int          hc;
    int          c0;
    logic [31:0] rdata;
    logic [31:0] exp;
    c0 = ce_cnt;
    sb.push_back(gold_rd(addr));
    access(tag, 1'b1, 1'b1, addr, 32'd0, hc, rdata);
    exp = sb.pop_front();
    chk({tag, "_data"}, rdata, exp);
    chk({tag, "_hold"}, 32'(hc), 32'(exp_hold));
    chk({tag, "_ce"}, 32'(ce_cnt - c0), 32'(exp_ce));
  endtask

  task automatic wr(input string tag, input logic bw, input logic [31:0] addr,
                    input logic [31:0] wdata, input int exp_hold, input int exp_ce);
    int          hc;
    int          c0;
    logic [31:0] rdata;
    logic [31:0] w;
    c0 = ce_cnt;
    w  = gold_rd(addr);
    if (bw) w = wdata;
    else    w[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
    gold[widx(addr)] = w;
    access(tag, 1'b0, bw, addr, wdata, hc, rdata);
    chk({tag, "_hold"}, 32'(hc), 32'(exp_hold));
    chk({tag, "_ce"}, 32'(ce_cnt - c0), 32'(exp_ce));
    chk({tag, "_waddr"}, last_wr_addr, {addr[31:2], 2'b00});
    chk({tag, "_wdata"}, last_wr_data, w);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hold"},  32'(cif.hold), 32'd0);
    chk({tag, "_ce_n"},  32'(mem_ce_n), 32'd1);
    chk({tag, "_we_n"},  32'(mem_we_n), 32'd1);
    chk({tag, "_oe_n"},  32'(mem_oe_n), 32'd1);
    chk({tag, "_bw"},    32'(mem_bw),   32'd1);
    chk({tag, "_addr"},  mem_addr, 32'd0);
    chk({tag, "_rdata"}, cif.cpu_rdata, 32'd0);
`ifdef L1_CACHE_STATS_EN
    chk({tag, "_hits"},   stat_hits,   32'd0);
    chk({tag, "_misses"}, stat_misses, 32'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset_n       = 1'b0;
    cif.cpu_ce_n  = 1'b1;
    cif.cpu_we_n  = 1'b1;
    cif.cpu_bw    = 1'b1;
    cif.cpu_addr  = 32'd0;
    cif.cpu_wdata = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("rst");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Cold read miss: four sequential word reads of the line
    base = rd_addrs.size();
    rd("miss40", 32'h40, 77, 4);
    chk("miss40_nreads", 32'(rd_addrs.size() - base), 32'd4);
    for (int i = 0; i < 4; i++)
      if (base + i < rd_addrs.size())
        chk($sformatf("miss40_addr%0d", i), rd_addrs[base + i], 32'h40 + 32'(4 * i));

    // Hit in the freshly filled line
    rd("hit44", 32'h44, 0, 0);

    // Word write hit, then read back
    wr("wr48", 1'b1, 32'h48, 32'hDEAD_BEEF, 19, 1);
    rd("rd48", 32'h48, 0, 0);

    // Byte write miss: refill then merged full-word write-through
    wr("bwr101", 1'b0, 32'h101, 32'h0000_00AB, 96, 5);
    rd("rd100", 32'h100, 0, 0);
    rd("rd10c", 32'h10C, 0, 0);

    // Conflict eviction on index 4
    rd("hit40", 32'h40, 0, 0);
    rd("conf440", 32'h440, 77, 4);
    rd("evict40", 32'h40, 77, 4);
    rd("rd48b", 32'h48, 0, 0);

    // Reset in the middle of a refill WAIT
    @(negedge clk);
    cif.cpu_ce_n = 1'b0;
    cif.cpu_we_n = 1'b1;
    cif.cpu_addr = 32'h80;
    repeat (8) @(negedge clk);
    #1;
    chk("wait_hold", 32'(cif.hold), 32'd1);
    chk("wait_oe_n", 32'(mem_oe_n), 32'd0);
    reset_n      = 1'b0;
    cif.cpu_ce_n = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    rd("post_rst80", 32'h80, 77, 4);
    rd("post_rst40", 32'h40, 77, 4);
`ifdef L1_CACHE_STATS_EN
    chk("stat_misses", stat_misses, 32'd2);
    chk("stat_hits0",  stat_hits,   32'd0);
    rd("hit80", 32'h80, 0, 0);
    chk("stat_hits1",  stat_hits,   32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/l1_cache_ctrl.md
Name: l1_cache_ctrl

Overview:
- Direct-mapped, write-through, write-allocate L1 cache between the multicycle MIPS core and the latency memory with ack.
- Core side is a synchronous request/hold interface: the core stalls while hold=1.
- Memory side drives the ce_n/we_n/oe_n/bw/address interface, shares the tristate 32-bit data bus, and waits on a one-cycle ack pulse.
- Line refill is LINE_WORDS sequential single-word reads.

Parameters:
- NUM_LINES, 16: number of cache lines; power of two, ≥2.
- LINE_WORDS, 4: 32-bit words per line; power of two, ≥1.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- cpu_ce_n  in  1  core request, active-low
- cpu_we_n  in  1  0=write, 1=read
- cpu_bw  in  1  1=word write; 0=byte write of cpu_wdata[7:0] into lane cpu_addr[1:0]
- cpu_addr  in  32  byte address; word-aligned for word accesses
- cpu_wdata  in  32  write data
- cpu_rdata  out  32  read data, valid when request active and hold=0
- hold  out  1  stall core
- mem_ce_n  out  1  memory request strobe
- mem_we_n  out  1  memory write enable
- mem_oe_n  out  1  memory output enable
- mem_bw  out  1  constant 1 (full-word access)
- mem_addr  out  32  memory word address
- mem_data  inout  32  shared data bus
- mem_ack  in  1  one-cycle completion pulse

Behaviour:
- Address split: [1:0] byte offset, next log2(LINE_WORDS) bits word offset, next log2(NUM_LINES) bits index, remainder tag.
- Per line state: valid bit, tag, LINE_WORDS data words.
- Reset clears all valid bits asynchronously. Tag and data arrays are not reset.
- Output reset values: hold=0, mem_ce_n=1, mem_we_n=1, mem_oe_n=1, mem_addr=0, mem_data released (Z), cpu_rdata=0, FSM=IDLE.
- hit = valid[index] && tag match, evaluated combinationally.
- FSM states:
  - IDLE: if cpu_ce_n=1, hold=0.
    - Read hit: cpu_rdata is the addressed word, same cycle; hold=0.
    - Miss (read or write): hold=1; latch line base (word offset cleared), k=0; go to REQ.
    - Write hit: merge the byte or word into the cached word at the clock edge; latch the merged word and address; hold=1; go to WB_REQ.
  - REQ: mem_ce_n=0, mem_we_n=1, mem_oe_n=0, mem_addr=base+4k; hold=1. Exactly one cycle, then WAIT.
  - WAIT: mem_ce_n=1, mem_oe_n=0, hold=1. On mem_ack=1, capture mem_data into line word k, then go to GAP.
  - GAP: one cycle, mem_ce_n=1, hold=1.
    - If k<LINE_WORDS-1: k++, go to REQ.
    - Else: set valid and tag, go to IDLE. The held request re-evaluates as a hit.
  - WB_REQ: mem_ce_n=0, mem_we_n=0, mem_addr=latched word address; drive mem_data=merged word; hold=1. One cycle, then WB_WAIT.
  - WB_WAIT: mem_ce_n=1, bus released, hold=1. On mem_ack go to DONE.
  - DONE: one cycle; hold=0 (core completes the write); mem_ce_n=1; go to IDLE.
- mem_ce_n is asserted for exactly one cycle per access, so the memory never sees a second capture.
- At least one mem_ce_n=1 cycle always separates an ack from the next request (GAP/DONE). This covers the memory's lingering data drive.
- mem_data is driven by this block only in WB_REQ. It is Z in every other state.
- Request inputs are sampled only in IDLE. The core holds them stable while hold=1.
- cpu_ce_n deasserting mid-miss or mid-write: the operation still runs to completion; the line still becomes valid.
- A write hit updates the cache before the memory write completes; write-through is unconditional.
- A byte-write miss refills the line, then merges and writes through the full word.
- The memory never acks an unmapped address: hold stays high indefinitely. Address range is the core's responsibility.
- Reset mid-operation: immediate return to IDLE, bus released, all lines invalid. A pending memory ack arriving later is ignored.

Optional Feature:
- Macro: L1_CACHE_STATS_EN.
- Defined: adds outputs stat_hits (32) and stat_misses (32), both reset to 0.
  - stat_hits increments once per core access that finds a hit on first IDLE evaluation.
  - stat_misses increments once per access that enters REQ from IDLE.
  - Both counters saturate at 0xFFFFFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Memory LATENCY=16, defaults. After reset, read 0x00000040 -> miss; 4 reads at 0x40,0x44,0x48,0x4C, one mem_ce_n pulse each; hold high 77 cycles (1+4×19); cpu_rdata = mem word at 0x40 with hold=0.
- Read 0x00000044 right after the previous fill -> hit; hold=0 same cycle; mem_ce_n stays 1; rdata = mem[0x44].
- Word write 0xDEADBEEF to cached 0x48 -> hold high 19 cycles, low 1 cycle in DONE; memory receives 0xDEADBEEF with mem_we_n=0; following read 0x48 hits, returns 0xDEADBEEF.
- Byte write 0xAB to uncached 0x00000101 (bw=0) -> 4-word refill of 0x100..0x10C, then write-through of the word with bits[15:8]=0xAB and other bytes from memory; read back matches.
- Conflict: read 0x40, then 0x40+16·NUM_LINES·... (0x440) -> second access misses, evicts; re-read 0x40 misses again.
- reset_n low during WAIT of a refill -> outputs at reset values; subsequent read of the same address misses and refills correctly; with L1_CACHE_STATS_EN counters read 0 after reset.
